// File: rtl/rr_forward_stage_pkg.sv
// Purpose     : shared widths, forwarding-source ordering and build options for the RR stage.
// Latency     : n/a (constants only).
// Backpressure: n/a.
// Build option: RR_WB_FORWARD_EN -- when defined, the WB stage is a live forwarding source;
//               when undefined, a WB match stalls until the GPR file holds the value.
package rr_forward_stage_pkg;

   // Architectural widths.
   localparam int GPR_NUM     = 5;    // GPR index width
   localparam int SINGLE_WORD = 32;   // operand / data width

   // Forwarding sources, nearest (youngest producer) first. The resolve logic
   // scans in ascending index order, so this order is the priority order.
   localparam int FWD_EXE   = 0;
   localparam int FWD_REEXE = 1;
   localparam int FWD_MEM   = 2;
   localparam int FWD_WB    = 3;
   localparam int FWD_SRCS  = 4;

`ifdef RR_WB_FORWARD_EN
   localparam bit WB_FWD_EN = 1'b1;
`else
   // WB still takes part in the match scan (so it shadows nothing older than
   // itself and is shadowed by REEXE/MEM), but its result is never used: the
   // operand waits until the value lands in the GPR file.
   localparam bit WB_FWD_EN = 1'b0;
`endif

endpackage

// File: rtl/rr_forward_stage_operand.sv
// Purpose     : resolves one source operand against EXE/REEXE/MEM/WB forwarding and the GPR file,
//               and captures it once resolved so it survives stalls on the other operand.
// Latency     : combinational value/ready; capture registered on the rising edge.
// Backpressure: ready_o low while the nearest matching producer has no result yet.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reg_num_i                     source register number (0 = $0)
//   fwd_mode_i/num_i/data_i       per-source forwarding triples, indexed by FWD_* order
//   gpr_data_i                    combinational GPR read data for reg_num_i
//   has_data_i/accept_i/flush_i   stage state and this cycle's accept / flush
//   value_o, ready_o              operand value and readiness (captured operand is always ready)
// Build option: RR_WB_FORWARD_EN (see package).
module rr_operand_resolve
   import rr_forward_stage_pkg::*;
#(
   parameter int DATA_W = SINGLE_WORD,
   parameter int REG_W  = GPR_NUM
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic [REG_W-1:0]                   reg_num_i,
   input  logic [FWD_SRCS-1:0]                fwd_mode_i,
   input  logic [FWD_SRCS-1:0][REG_W-1:0]     fwd_num_i,
   input  logic [FWD_SRCS-1:0][DATA_W-1:0]    fwd_data_i,
   input  logic [DATA_W-1:0]                  gpr_data_i,
   input  logic                               has_data_i,
   input  logic                               accept_i,
   input  logic                               flush_i,
   output logic [DATA_W-1:0]                  value_o,
   output logic                               ready_o
);

   logic              got_q, got_d;
   logic [DATA_W-1:0] cap_q, cap_d;

   logic              res_rdy;
   logic [DATA_W-1:0] res_val;
   logic              matched;

   // Live resolution. Only the first (nearest) matching source counts: if it
   // has no result yet, older producers of the same register hold stale data
   // and must not be used, so the scan stops there either way.
   always_comb begin
      res_rdy = 1'b1;
      res_val = gpr_data_i;
      matched = 1'b0;
      if (reg_num_i == '0) begin
         res_val = '0;
      end else begin
         for (int i = 0; i < FWD_SRCS; i++) begin
            if (!matched && (fwd_num_i[i] == reg_num_i)) begin
               matched = 1'b1;
               res_rdy = fwd_mode_i[i] && (WB_FWD_EN || (i != FWD_WB));
               res_val = fwd_data_i[i];
            end
         end
      end
   end

   assign ready_o = got_q || res_rdy;
   assign value_o = got_q ? cap_q : res_val;

   // Capture bookkeeping. Flush wins over accept, accept wins over capture:
   // a freshly accepted instruction starts with nothing captured.
   always_comb begin
      got_d = got_q;
      cap_d = cap_q;
      if (flush_i) begin
         got_d = 1'b0;
         cap_d = '0;
      end else if (accept_i) begin
         got_d = 1'b0;
      end else if (has_data_i && !got_q && res_rdy) begin
         got_d = 1'b1;
         cap_d = res_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         got_q <= 1'b0;
         cap_q <= '0;
      end else begin
         got_q <= got_d;
         cap_q <= cap_d;
      end
   end

endmodule

// File: rtl/rr_forward_stage.sv
// Purpose     : register-read stage between ID and EXE; holds one instruction and resolves rs/rt
//               through EXE/REEXE/MEM/WB forwarding with nearest-stage priority.
// Latency     : one cycle from accept to handoff when no hazard; full back-to-back throughput.
// Backpressure: RR_allowin_w_o drops while an operand's nearest producer is not ready or EXE
//               refuses; flush_w_i discards the held instruction and beats accept/handoff.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   ID_*                                  incoming instruction (valid, rs, rt, dest, PC)
//   RR_allowin_w_o                        stage can take from ID this cycle
//   RR_rsNum_w_o/RR_rtNum_w_o             GPR read addresses, GPR_*Data_w_i read data
//   {EXE,REEXE,MEM,WB}_*_w_i              forwarding ports (mode, dest, data)
//   EXE_allowin_w_i, flush_w_i            downstream accept, pipeline flush
//   RR_valid_w_o, RR_writeNum_o, RR_VAddr_o, RR_rsData_o, RR_rtData_o   handoff to EXE
// Build option: RR_WB_FORWARD_EN (see package).
module rr_forward_stage
   import rr_forward_stage_pkg::*;
#(
   parameter int DATA_W = SINGLE_WORD,
   parameter int REG_W  = GPR_NUM
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              ID_valid_w_i,
   input  logic [REG_W-1:0]  ID_rsNum_i,
   input  logic [REG_W-1:0]  ID_rtNum_i,
   input  logic [REG_W-1:0]  ID_writeNum_i,
   input  logic [DATA_W-1:0] ID_VAddr_i,
   output logic              RR_allowin_w_o,
   output logic [REG_W-1:0]  RR_rsNum_w_o,
   output logic [REG_W-1:0]  RR_rtNum_w_o,
   input  logic [DATA_W-1:0] GPR_rsData_w_i,
   input  logic [DATA_W-1:0] GPR_rtData_w_i,
   input  logic              EXE_forwardMode_w_i,
   input  logic [REG_W-1:0]  EXE_writeNum_w_i,
   input  logic [DATA_W-1:0] EXE_regData_w_i,
   input  logic              REEXE_forwardMode_w_i,
   input  logic [REG_W-1:0]  REEXE_writeNum_w_i,
   input  logic [DATA_W-1:0] REEXE_regData_w_i,
   input  logic              MEM_forwardMode_w_i,
   input  logic [REG_W-1:0]  MEM_writeNum_w_i,
   input  logic [DATA_W-1:0] MEM_regData_w_i,
   input  logic              WB_forwardMode_w_i,
   input  logic [REG_W-1:0]  WB_writeNum_w_i,
   input  logic [DATA_W-1:0] WB_regData_w_i,
   input  logic              EXE_allowin_w_i,
   input  logic              flush_w_i,
   output logic              RR_valid_w_o,
   output logic [REG_W-1:0]  RR_writeNum_o,
   output logic [DATA_W-1:0] RR_VAddr_o,
   output logic [DATA_W-1:0] RR_rsData_o,
   output logic [DATA_W-1:0] RR_rtData_o
);

   // Stage registers.
   logic              has_data_q, has_data_d;
   logic [REG_W-1:0]  rs_num_q,   rs_num_d;
   logic [REG_W-1:0]  rt_num_q,   rt_num_d;
   logic [REG_W-1:0]  write_num_q, write_num_d;
   logic [DATA_W-1:0] vaddr_q,    vaddr_d;

   logic rs_ready, rt_ready, ready, accept;

   // Forwarding ports gathered into source-ordered arrays for the resolvers.
   logic [FWD_SRCS-1:0]             fwd_mode;
   logic [FWD_SRCS-1:0][REG_W-1:0]  fwd_num;
   logic [FWD_SRCS-1:0][DATA_W-1:0] fwd_data;

   assign fwd_mode[FWD_EXE]   = EXE_forwardMode_w_i;
   assign fwd_mode[FWD_REEXE] = REEXE_forwardMode_w_i;
   assign fwd_mode[FWD_MEM]   = MEM_forwardMode_w_i;
   assign fwd_mode[FWD_WB]    = WB_forwardMode_w_i;

   assign fwd_num[FWD_EXE]    = EXE_writeNum_w_i;
   assign fwd_num[FWD_REEXE]  = REEXE_writeNum_w_i;
   assign fwd_num[FWD_MEM]    = MEM_writeNum_w_i;
   assign fwd_num[FWD_WB]     = WB_writeNum_w_i;

   assign fwd_data[FWD_EXE]   = EXE_regData_w_i;
   assign fwd_data[FWD_REEXE] = REEXE_regData_w_i;
   assign fwd_data[FWD_MEM]   = MEM_regData_w_i;
   assign fwd_data[FWD_WB]    = WB_regData_w_i;

   // Handshake. Allow-in depends only on state, forwarding ports and
   // EXE_allowin_w_i -- never on ID_* -- so no ID-to-output path exists.
   assign ready          = rs_ready && rt_ready;
   assign RR_valid_w_o   = has_data_q && ready && EXE_allowin_w_i && !flush_w_i;
   assign RR_allowin_w_o = !has_data_q || (ready && EXE_allowin_w_i);
   assign accept         = ID_valid_w_i && RR_allowin_w_o && !flush_w_i;

   assign RR_rsNum_w_o   = rs_num_q;
   assign RR_rtNum_w_o   = rt_num_q;
   assign RR_writeNum_o  = write_num_q;
   assign RR_VAddr_o     = vaddr_q;

   rr_operand_resolve #(.DATA_W(DATA_W), .REG_W(REG_W)) u_rs (
      .clk        (clk),
      .rst        (rst),
      .reg_num_i  (rs_num_q),
      .fwd_mode_i (fwd_mode),
      .fwd_num_i  (fwd_num),
      .fwd_data_i (fwd_data),
      .gpr_data_i (GPR_rsData_w_i),
      .has_data_i (has_data_q),
      .accept_i   (accept),
      .flush_i    (flush_w_i),
      .value_o    (RR_rsData_o),
      .ready_o    (rs_ready)
   );

   rr_operand_resolve #(.DATA_W(DATA_W), .REG_W(REG_W)) u_rt (
      .clk        (clk),
      .rst        (rst),
      .reg_num_i  (rt_num_q),
      .fwd_mode_i (fwd_mode),
      .fwd_num_i  (fwd_num),
      .fwd_data_i (fwd_data),
      .gpr_data_i (GPR_rtData_w_i),
      .has_data_i (has_data_q),
      .accept_i   (accept),
      .flush_i    (flush_w_i),
      .value_o    (RR_rtData_o),
      .ready_o    (rt_ready)
   );

   // Flush clears everything; otherwise an accept refills the stage (this also
   // covers handoff-plus-accept in one cycle); a bare handoff empties it.
   always_comb begin
      has_data_d  = has_data_q;
      rs_num_d    = rs_num_q;
      rt_num_d    = rt_num_q;
      write_num_d = write_num_q;
      vaddr_d     = vaddr_q;
      if (flush_w_i) begin
         has_data_d  = 1'b0;
         rs_num_d    = '0;
         rt_num_d    = '0;
         write_num_d = '0;
         vaddr_d     = '0;
      end else if (accept) begin
         has_data_d  = 1'b1;
         rs_num_d    = ID_rsNum_i;
         rt_num_d    = ID_rtNum_i;
         write_num_d = ID_writeNum_i;
         vaddr_d     = ID_VAddr_i;
      end else if (RR_valid_w_o) begin
         has_data_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         has_data_q  <= 1'b0;
         rs_num_q    <= '0;
         rt_num_q    <= '0;
         write_num_q <= '0;
         vaddr_q     <= '0;
      end else begin
         has_data_q  <= has_data_d;
         rs_num_q    <= rs_num_d;
         rt_num_q    <= rt_num_d;
         write_num_q <= write_num_d;
         vaddr_q     <= vaddr_d;
      end
   end

endmodule

// File: tb/tb_rr_forward_stage.sv
// Purpose     : self-checking bench for rr_forward_stage: directed table, hand-written multi-cycle
//               sequences, and randomized traffic against a behavioural reference model.
// Build option: RR_WB_FORWARD_EN changes the expected WB behaviour.
module tb_rr_forward_stage;

`ifdef RR_WB_FORWARD_EN
   localparam bit WB_ON = 1'b1;
`else
   localparam bit WB_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_wn;
   logic [31:0] id_va;
   logic [31:0] gpr_rs, gpr_rt;
   logic        fm [4];
   logic [4:0]  wn [4];
   logic [31:0] wd [4];
   logic        exe_al, flush;

   logic        allowin, valid;
   logic [4:0]  rs_num, rt_num, wn_o;
   logic [31:0] va_o, rs_d, rt_d;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rr_forward_stage dut (
      .clk                   (clk),
      .rst                   (rst),
      .ID_valid_w_i          (id_valid),
      .ID_rsNum_i            (id_rs),
      .ID_rtNum_i            (id_rt),
      .ID_writeNum_i         (id_wn),
      .ID_VAddr_i            (id_va),
      .RR_allowin_w_o        (allowin),
      .RR_rsNum_w_o          (rs_num),
      .RR_rtNum_w_o          (rt_num),
      .GPR_rsData_w_i        (gpr_rs),
      .GPR_rtData_w_i        (gpr_rt),
      .EXE_forwardMode_w_i   (fm[0]),
      .EXE_writeNum_w_i      (wn[0]),
      .EXE_regData_w_i       (wd[0]),
      .REEXE_forwardMode_w_i (fm[1]),
      .REEXE_writeNum_w_i    (wn[1]),
      .REEXE_regData_w_i     (wd[1]),
      .MEM_forwardMode_w_i   (fm[2]),
      .MEM_writeNum_w_i      (wn[2]),
      .MEM_regData_w_i       (wd[2]),
      .WB_forwardMode_w_i    (fm[3]),
      .WB_writeNum_w_i       (wn[3]),
      .WB_regData_w_i        (wd[3]),
      .EXE_allowin_w_i       (exe_al),
      .flush_w_i             (flush),
      .RR_valid_w_o          (valid),
      .RR_writeNum_o         (wn_o),
      .RR_VAddr_o            (va_o),
      .RR_rsData_o           (rs_d),
      .RR_rtData_o           (rt_d)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      id_valid = 1'b0; id_rs = '0; id_rt = '0; id_wn = '0; id_va = '0;
      gpr_rs = '0; gpr_rt = '0; exe_al = 1'b1; flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fm[i] = 1'b0; wn[i] = '0; wd[i] = '0;
      end
   endtask

   // One-cycle resolve vectors: instruction accepted, then forwarding ports
   // applied in the following cycle (GPR reads 0x11 / 0x22). Index 0 = EXE.
   typedef struct {
      string            name;
      logic [4:0]       rs, rt;
      logic [3:0]       fm;
      logic [3:0][4:0]  wn;
      logic [3:0][31:0] wd;
      logic             exp_vld;
      logic [31:0]      exp_rs, exp_rt;
   } vec_t;

   function automatic vec_t mkv(string name, logic [4:0] rs, logic [4:0] rt, logic [3:0] f,
                                logic [4:0] w0, logic [4:0] w1, logic [4:0] w2, logic [4:0] w3,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3,
                                logic ev, logic [31:0] er, logic [31:0] et);
      vec_t v;
      v.name = name; v.rs = rs; v.rt = rt; v.fm = f;
      v.wn[0] = w0; v.wn[1] = w1; v.wn[2] = w2; v.wn[3] = w3;
      v.wd[0] = d0; v.wd[1] = d1; v.wd[2] = d2; v.wd[3] = d3;
      v.exp_vld = ev; v.exp_rs = er; v.exp_rt = et;
      return v;
   endfunction

   // Reference resolve straight from the forwarding rules: $0 is zero; else the
   // first source in EXE..WB order naming the register decides; else the GPR.
   function automatic void ref_resolve(input logic [4:0] n, input logic [31:0] gpr,
                                       output bit rdy, output logic [31:0] val);
      rdy = 1'b1;
      val = gpr;
      if (n == 5'd0) begin
         val = '0;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         if (wn[i] == n) begin
            rdy = fm[i] && !(i == 3 && !WB_ON);
            val = wd[i];
            return;
         end
      end
   endfunction

   // Reference model state: the held instruction and per-operand capture.
   bit          m_has, m_rs_got, m_rt_got;
   logic [4:0]  m_rs, m_rt, m_wn;
   logic [31:0] m_va, m_rs_cap, m_rt_cap;

   vec_t vecs [10];

   initial begin
      bit          rs_r, rt_r, rs_ok, rt_ok, e_valid, e_allow;
      logic [31:0] rs_v, rt_v, o_rs, o_rt;

      vecs[0] = mkv("nohaz",      5'd3, 5'd4, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 32'h22);
      vecs[1] = mkv("exe_prio",   5'd5, 5'd4, 4'b0101, 5, 0, 5, 0, 32'hA, 0, 32'hB, 0, 1, 32'hA, 32'h22);
      vecs[2] = mkv("exe_shadow", 5'd5, 5'd4, 4'b0100, 5, 0, 5, 0, 32'hA, 0, 32'hB, 0, 0, 0, 0);
      vecs[3] = mkv("zero_reg",   5'd0, 5'd4, 4'b0000, 0, 0, 0, 0, 32'h5, 0, 0, 0, 1, 32'h0, 32'h22);
      vecs[4] = mkv("reexe_fwd",  5'd3, 5'd4, 4'b0010, 0, 4, 0, 0, 0, 32'h33, 0, 0, 1, 32'h11, 32'h33);
      vecs[5] = mkv("reexe_shad", 5'd3, 5'd4, 4'b1000, 0, 4, 0, 4, 0, 0, 0, 32'h44, 0, 0, 0);
      vecs[6] = mkv("wb_fwd",     5'd7, 5'd4, 4'b1000, 0, 0, 0, 7, 0, 0, 0, 32'hD, WB_ON, 32'hD, 32'h22);
      vecs[7] = mkv("mem_both",   5'd9, 5'd9, 4'b0100, 0, 0, 9, 0, 0, 0, 32'h99, 0, 1, 32'h99, 32'h99);
      vecs[8] = mkv("rt_pend",    5'd3, 5'd4, 4'b0000, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[9] = mkv("mix",        5'd3, 5'd4, 4'b0100, 6, 0, 4, 0, 0, 0, 32'h55, 0, 1, 32'h11, 32'h55);

      // ---- Reset: ID_valid held high must not load anything.
      idle();
      rst = 1'b1;
      id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_wn = 5'd9; id_va = 32'hDEAD0000;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_allowin", 32'(allowin), 32'd1);
      chk("rst_valid",   32'(valid),   32'd0);
      chk("rst_rsdata",  rs_d,         32'd0);
      chk("rst_rtdata",  rt_d,         32'd0);
      chk("rst_wn",      32'(wn_o),    32'd0);
      chk("rst_va",      va_o,         32'd0);
      idle();
      rst = 1'b0;

      // ---- Table: accept, then one cycle of forwarding conditions.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); idle(); flush = 1'b1;
         @(negedge clk); idle();
         id_valid = 1'b1; id_rs = vecs[k].rs; id_rt = vecs[k].rt;
         id_wn = 5'd1; id_va = 32'h100 + 32'(k);
         @(negedge clk); idle();
         gpr_rs = 32'h11; gpr_rt = 32'h22;
         for (int i = 0; i < 4; i++) begin
            fm[i] = vecs[k].fm[i]; wn[i] = vecs[k].wn[i]; wd[i] = vecs[k].wd[i];
         end
         #1;
         chk({vecs[k].name, "_valid"},   32'(valid),   32'(vecs[k].exp_vld));
         chk({vecs[k].name, "_allowin"}, 32'(allowin), 32'(vecs[k].exp_vld));
         chk({vecs[k].name, "_rsnum"},   32'(rs_num),  32'(vecs[k].rs));
         if (vecs[k].exp_vld) begin
            chk({vecs[k].name, "_rs"}, rs_d, vecs[k].exp_rs);
            chk({vecs[k].name, "_rt"}, rt_d, vecs[k].exp_rt);
            chk({vecs[k].name, "_va"}, va_o, 32'h100 + 32'(k));
         end
      end

      // ---- Capture: rs from MEM, rt pending on EXE for 3 cycles, MEM retires.
      @(negedge clk); idle(); flush = 1'b1;
      @(negedge clk); idle();
      id_valid = 1'b1; id_rs = 5'd10; id_rt = 5'd11; id_wn = 5'd2; id_va = 32'h200;
      @(negedge clk); idle();
      wn[2] = 5'd10; fm[2] = 1'b1; wd[2] = 32'hC;
      wn[0] = 5'd11; fm[0] = 1'b0; wd[0] = 32'hBAD;
      #1; chk("cap_c1_valid", 32'(valid), 32'd0);
      @(negedge clk);
      wn[2] = '0; fm[2] = 1'b0; wd[2] = '0; gpr_rs = 32'h0;
      #1; chk("cap_c2_valid", 32'(valid), 32'd0);
      chk("cap_c2_allowin", 32'(allowin), 32'd0);
      @(negedge clk);
      #1; chk("cap_c3_valid", 32'(valid), 32'd0);
      @(negedge clk);
      fm[0] = 1'b1; wd[0] = 32'h44;
      #1; chk("cap_c4_valid", 32'(valid), 32'd1);
      chk("cap_c4_rs", rs_d, 32'hC);
      chk("cap_c4_rt", rt_d, 32'h44);

      // ---- Downstream stall, back-to-back accept, then flush with ID valid.
      @(negedge clk); idle(); flush = 1'b1;
      @(negedge clk); idle();
      id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_wn = 5'h12; id_va = 32'hBFC00010;
      @(negedge clk); idle();
      gpr_rs = 32'h11; gpr_rt = 32'h22; exe_al = 1'b0;
      #1; chk("stall1_allowin", 32'(allowin), 32'd0);
      chk("stall1_valid", 32'(valid), 32'd0);
      chk("stall1_wn", 32'(wn_o), 32'h12);
      @(negedge clk);
      gpr_rs = 32'h77;   // operands were captured during the stall
      #1; chk("stall2_allowin", 32'(allowin), 32'd0);
      chk("stall2_va", va_o, 32'hBFC00010);
      @(negedge clk);
      exe_al = 1'b1;
      id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_wn = 5'h13; id_va = 32'h300;
      #1; chk("rel_valid", 32'(valid), 32'd1);
      chk("rel_allowin", 32'(allowin), 32'd1);
      chk("rel_rs_captured", rs_d, 32'h11);
      @(negedge clk);
      id_valid = 1'b1; id_wn = 5'h14; flush = 1'b1; gpr_rs = 32'h11;
      #1; chk("flush_valid", 32'(valid), 32'd0);
      chk("b2b_wn", 32'(wn_o), 32'h13);
      @(negedge clk); idle();
      #1; chk("postflush_valid", 32'(valid), 32'd0);
      chk("postflush_allowin", 32'(allowin), 32'd1);
      chk("postflush_wn", 32'(wn_o), 32'd0);

      // ---- WB producer for rs=7, GPR stale until WB retires.
      @(negedge clk); idle(); flush = 1'b1;
      @(negedge clk); idle();
      id_valid = 1'b1; id_rs = 5'd7; id_rt = 5'd0; id_wn = 5'd1; id_va = 32'h400;
      @(negedge clk); idle();
      wn[3] = 5'd7; fm[3] = 1'b1; wd[3] = 32'hD; gpr_rs = 32'h0;
      #1;
`ifdef RR_WB_FORWARD_EN
      chk("wb_c1_valid", 32'(valid), 32'd1);
      chk("wb_c1_rs", rs_d, 32'hD);
`else
      chk("wb_c1_valid", 32'(valid), 32'd0);
      @(negedge clk);
      wn[3] = '0; fm[3] = 1'b0; wd[3] = '0; gpr_rs = 32'hD;
      #1;
      chk("wb_c2_valid", 32'(valid), 32'd1);
      chk("wb_c2_rs", rs_d, 32'hD);
`endif

      // ---- Randomized traffic against the reference model.
      @(negedge clk); idle(); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      m_has = 0; m_rs_got = 0; m_rt_got = 0;
      m_rs = '0; m_rt = '0; m_wn = '0; m_va = '0; m_rs_cap = '0; m_rt_cap = '0;
      for (int c = 0; c < 3000; c++) begin
         if (c != 0) @(negedge clk);
         id_valid = 1'($urandom_range(0, 1));
         id_rs    = 5'($urandom_range(0, 7));
         id_rt    = 5'($urandom_range(0, 7));
         id_wn    = 5'($urandom_range(0, 31));
         id_va    = $urandom;
         gpr_rs   = $urandom;
         gpr_rt   = $urandom;
         for (int i = 0; i < 4; i++) begin
            fm[i] = ($urandom_range(0, 2) != 0);
            wn[i] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            wd[i] = $urandom;
         end
         exe_al = ($urandom_range(0, 3) != 0);
         flush  = ($urandom_range(0, 15) == 0);
         #1;
         ref_resolve(m_rs, gpr_rs, rs_r, rs_v);
         ref_resolve(m_rt, gpr_rt, rt_r, rt_v);
         rs_ok   = m_rs_got || rs_r;
         rt_ok   = m_rt_got || rt_r;
         o_rs    = m_rs_got ? m_rs_cap : rs_v;
         o_rt    = m_rt_got ? m_rt_cap : rt_v;
         e_valid = m_has && rs_ok && rt_ok && exe_al && !flush;
         e_allow = !m_has || (rs_ok && rt_ok && exe_al);
         chk("rnd_valid",   32'(valid),   32'(e_valid));
         chk("rnd_allowin", 32'(allowin), 32'(e_allow));
         chk("rnd_rsnum",   32'(rs_num),  32'(m_rs));
         chk("rnd_rtnum",   32'(rt_num),  32'(m_rt));
         if (e_valid) begin
            chk("rnd_rs", rs_d, o_rs);
            chk("rnd_rt", rt_d, o_rt);
            chk("rnd_wn", 32'(wn_o), 32'(m_wn));
            chk("rnd_va", va_o, m_va);
         end
         // Next model state.
         if (flush) begin
            m_has = 0; m_rs_got = 0; m_rt_got = 0;
            m_rs = '0; m_rt = '0; m_wn = '0; m_va = '0;
         end else if (id_valid && e_allow) begin
            m_has = 1; m_rs_got = 0; m_rt_got = 0;
            m_rs = id_rs; m_rt = id_rt; m_wn = id_wn; m_va = id_va;
         end else begin
            if (m_has && !m_rs_got && rs_r) begin m_rs_got = 1; m_rs_cap = rs_v; end
            if (m_has && !m_rt_got && rt_r) begin m_rt_got = 1; m_rt_cap = rt_v; end
            if (e_valid) m_has = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_forward_stage.md
# rr_forward_stage

Register-read stage sitting between decode (ID) and execute (EXE). It holds one instruction and reads `rs`/`rt` from the GPR file. Each operand is resolved against the forwarding ports of the downstream stages EXE, REEXE, MEM and WB, with the nearest stage taking priority. The stage stalls while the nearest matching producer is not yet ready, and once an operand has been resolved it is captured so a stall on the other operand cannot lose it.

## Interface
- `DATA_W`, 32, operand/data width (`SINGLE_WORD`)
- `REG_W`, 5, GPR index width (`GPR_NUM`)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ID_valid_w_i`  in  1  ID presents an instruction
- `ID_rsNum_i`, `ID_rtNum_i`  in  REG_W  source registers; 0 = `$0`
- `ID_writeNum_i`  in  REG_W  destination, 0 = no write
- `ID_VAddr_i`  in  DATA_W  PC for debug/exceptions
- `RR_allowin_w_o`  out  1  stage can accept from ID this cycle
- `RR_rsNum_w_o`, `RR_rtNum_w_o`  out  REG_W  GPR file read addresses (from stage register)
- `GPR_rsData_w_i`, `GPR_rtData_w_i`  in  DATA_W  GPR file read data, combinational
- `X_forwardMode_w_i`  in  1  for X ∈ {EXE, REEXE, MEM, WB}: X holds a valid result now
- `X_writeNum_w_i`  in  REG_W  X destination, 0 = none
- `X_regData_w_i`  in  DATA_W  X result
- `EXE_allowin_w_i`  in  1  EXE accepts this cycle
- `flush_w_i`  in  1  discard held instruction
- `RR_valid_w_o`  out  1  instruction handed to EXE this cycle
- `RR_writeNum_o`  out  REG_W  destination to EXE
- `RR_VAddr_o`  out  DATA_W  PC to EXE
- `RR_rsData_o`, `RR_rtData_o`  out  DATA_W  resolved operands

## Operation
- State:
  - `hasData`
  - stage registers: `rsNum`, `rtNum`, `writeNum`, `VAddr`
  - per operand: `got` flag and `cap` data register
- Accept: `ID_valid_w_i && RR_allowin_w_o && !flush_w_i` loads the stage registers, sets `hasData`, and clears both `got`.
- Resolve each operand that has `got=0`, using register number `n`:
  - If `n==0`: value 0, ready.
  - Otherwise take the first X in order EXE, REEXE, MEM, WB with `X_writeNum_w_i==n`.
    - Match found with `forwardMode=1`: value is `X_regData_w_i`, ready.
    - Match found with `forwardMode=0`: not ready, and later stages are ignored (a newer producer shadows older ones).
  - No match: value is `GPR_*Data_w_i`, ready.
- Capture: while `hasData`, an operand that is ready with `got=0` sets `got=1` and loads `cap`. Operand output = `got ? cap : resolved value`.
- `ready = rsReady && rtReady`, where a `got` operand counts as ready.
- `RR_valid_w_o = hasData && ready && EXE_allowin_w_i && !flush_w_i`
- `RR_allowin_w_o = !hasData || (ready && EXE_allowin_w_i)`
- `hasData` update:
  - cleared on handoff with no new accept;
  - cleared on `flush_w_i`;
  - otherwise held.
- Flush priority: `flush_w_i` beats accept and handoff in the same cycle. `hasData`, `got` and the stage registers all clear to 0.

## Timing
- Reset values: every register is 0, so `RR_valid_w_o=0`, `RR_allowin_w_o=1`, and all data outputs are 0.
- Latency: an accepted instruction with no hazards is handed off on the next cycle (one stage).
- A load-use dependency with EXE `forwardMode=0` stalls one cycle per cycle that EXE stays not ready. The first cycle the result is ready, `RR_valid_w_o` may assert, given `EXE_allowin_w_i`.
- Back-to-back: handoff and a new accept can happen in the same cycle, giving full throughput.
- `got` operands are immune to forwarding-port changes, e.g. a producer retiring past WB during a downstream stall.
- Outputs are combinational from state and forwarding ports. No combinational path runs from `ID_*` to any output except through `RR_allowin_w_o`'s dependence on `EXE_allowin_w_i`.

## Configuration
- `RR_WB_FORWARD_EN` defined: WB is a forwarding source as described above.
- `RR_WB_FORWARD_EN` undefined:
  - the WB ports are unused;
  - a WB match is treated as not ready, so the stage stalls until the GPR file holds the value (GPR write at end of WB, readable next cycle).
- REEXE/MEM matches still shadow WB in both modes.

## Structure
- Shared package/defines:
  - `GPR_NUM`, `SINGLE_WORD` width macros
  - forwarding source order constants (`FWD_EXE=0` … `FWD_WB=3`)
- Sub-module `rr_operand_resolve`, instantiated twice (`rs`, `rt`):
  - inputs: register number, four forwarding triples, GPR data, stage `hasData`/accept/flush
  - outputs: value and ready
  - owns that operand's `got`/`cap` registers
- The top level holds `hasData`, the stage registers and the handshake.

## Test plan
- **Reset:** `rst=1` for 2 cycles → `RR_allowin_w_o=1`, `RR_valid_w_o=0`, all data outputs 0; hold `ID_valid_w_i=1` during reset → nothing accepted.
- **No hazard:** accept `rs=3`, `rt=4`, GPR data 0x11/0x22, no matches → next cycle `RR_valid_w_o=1`, `RR_rsData_o=0x11`, `RR_rtData_o=0x22`.
- **Priority and shadowing:**
  - `rs=5`; EXE write 5 with `forwardMode=1` data 0xA; MEM write 5 data 0xB → `RR_rsData_o=0xA`.
  - Same but EXE `forwardMode=0` → stall; MEM value ignored.
- **Capture:**
  - `rs` resolved from MEM (0xC), `rt` pending on EXE for 3 cycles; MEM then retires and GPR still reads 0 → on release `RR_rsData_o=0xC`, `RR_valid_w_o` asserts in cycle 4.
- **Downstream stall + flush:**
  - `EXE_allowin_w_i=0` for 2 cycles → `RR_allowin_w_o=0`, instruction held.
  - `flush_w_i` together with `ID_valid_w_i` → next cycle `hasData=0`, `RR_valid_w_o=0`, `RR_allowin_w_o=1`.
- **`$0` and WB config:**
  - `rs=0` with EXE writing 0 pending → no stall, value 0.
  - WB write 7 data 0xD, `rs=7`: with `RR_WB_FORWARD_EN` → 0xD in 1 cycle; without it → one-cycle stall, then the GPR value.
